// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// pipeline WB stage (always wins) and a small FIFO of multi-cycle unit (MDU)
// results, and keeps a busy scoreboard so decode stalls on pending MDU writes.
// Optional feature: define RF_WB_ARB_BYPASS_EN to let an accepted MDU result
// write the register file in its acceptance cycle when the FIFO is empty and
// WB is idle.
module rf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_wd,
    input  logic                     mdu_valid,
    input  logic [4:0]               mdu_rd,
    input  logic [31:0]              mdu_wd,
    output logic                     mdu_ready,
    input  logic                     iss_valid,
    input  logic [4:0]               iss_rd,
    input  logic                     dec_valid,
    input  logic [4:0]               dec_rs1,
    input  logic [4:0]               dec_rs2,
    input  logic [4:0]               dec_rd,
    output logic                     stall,
    output logic                     rf_we,
    output logic [4:0]               rf_a3,
    output logic [31:0]              rf_wd,
    output logic [$clog2(DEPTH):0]   buf_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    buf_rd [DEPTH];
    logic [31:0]   buf_wd [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    // bit 0 exists only to keep indexing uniform; it is forced to zero
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    logic          wb_write;
    logic          buf_empty;
    logic          buf_full;
    logic          pop;
    logic          accept;
    logic          keep;
    logic          bypass;
    logic          push;
    logic          ret_valid;
    logic [4:0]    ret_rd;
    logic [31:0]   ret_mask;
    logic [31:0]   set_mask;
    logic [31:0]   busy_eff;

    // Arbitration, FIFO handshake and retirement decode
    always_comb begin
        wb_write  = wb_we & (wb_rd != 5'd0);
        buf_empty = (cnt == '0);
        buf_full  = (cnt == CW'(DEPTH));
        pop       = ~rst & ~wb_write & ~buf_empty;
        // while in reset the unit is told it may offer; offers are dropped
        mdu_ready = rst | ~buf_full | pop;
        accept    = mdu_valid & mdu_ready & ~rst;
        keep      = accept & (mdu_rd != 5'd0);
`ifdef RF_WB_ARB_BYPASS_EN
        bypass    = keep & buf_empty & ~wb_write;
`else
        bypass    = 1'b0;
`endif
        push      = keep & ~bypass;
        ret_valid = pop | bypass;
        ret_rd    = pop ? buf_rd[rd_ptr] : mdu_rd;
        ret_mask  = ret_valid ? (32'd1 << ret_rd) : 32'd0;
        set_mask  = (iss_valid & (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
        // issue sets after retire clears, so a same-cycle reissue stays busy
        busy_next = ((busy & ~ret_mask) | set_mask) & ~32'd1;
    end

    // Register-file write port mux: WB, then FIFO head, then direct bypass
    always_comb begin
        rf_we = 1'b0;
        rf_a3 = 5'd0;
        rf_wd = 32'd0;
        if (!rst) begin
            if (wb_write) begin
                rf_we = 1'b1;
                rf_a3 = wb_rd;
                rf_wd = wb_wd;
            end else if (pop) begin
                rf_we = 1'b1;
                rf_a3 = buf_rd[rd_ptr];
                rf_wd = buf_wd[rd_ptr];
            end else if (bypass) begin
                rf_we = 1'b1;
                rf_a3 = mdu_rd;
                rf_wd = mdu_wd;
            end
        end
    end

    // Decode hazard check; a register retiring now is forwarded by the RF
    always_comb begin
        busy_eff = busy & ~ret_mask;
        stall    = 1'b0;
        if (dec_valid && !rst) begin
            stall = busy_eff[dec_rs1] | busy_eff[dec_rs2] | busy_eff[dec_rd];
        end
    end

    // Pointer, occupancy and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            busy   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt  <= cnt + CW'(push) - CW'(pop);
            busy <= busy_next;
        end
    end

    // FIFO payload storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd[wr_ptr] <= mdu_rd;
            buf_wd[wr_ptr] <= mdu_wd;
        end
    end

    assign buf_cnt = cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal
// expectations followed by a randomized run against a queue-based model.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RF_WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_wd;
    logic          mdu_valid;
    logic [4:0]    mdu_rd;
    logic [31:0]   mdu_wd;
    logic          mdu_ready;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic          dec_valid;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic [4:0]    dec_rd;
    logic          stall;
    logic          rf_we;
    logic [4:0]    rf_a3;
    logic [31:0]   rf_wd;
    logic [CW-1:0] buf_cnt;

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
        .mdu_ready(mdu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .stall(stall),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .buf_cnt(buf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // next-cycle stimulus
    bit          n_rst, n_wb_we, n_mdu_valid, n_iss_valid, n_dec_valid;
    logic [4:0]  n_wb_rd, n_mdu_rd, n_iss_rd, n_rs1, n_rs2, n_drd;
    logic [31:0] n_wb_wd, n_mdu_wd;

    // reference model state
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;
    ent_t mq[$];
    bit   mbusy[32];
    bit   m_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        n_rst = 0; n_wb_we = 0; n_mdu_valid = 0; n_iss_valid = 0; n_dec_valid = 0;
        n_wb_rd = 0; n_mdu_rd = 0; n_iss_rd = 0; n_rs1 = 0; n_rs2 = 0; n_drd = 0;
        n_wb_wd = 0; n_mdu_wd = 0;
    endtask

    // Compute what the outputs must be this cycle, compare, then advance the model
    task automatic model_check();
        bit          wbw, pop, rdy, acc, byp, st;
        int          n;
        bit          e_we;
        logic [4:0]  e_a3, ret;
        logic [31:0] e_wd;
        logic [4:0]  regs[3];
        wbw  = wb_we && (wb_rd != 0);
        n    = mq.size();
        pop  = !rst && !wbw && n > 0;
        rdy  = rst || n < DEPTH || pop;
        acc  = !rst && mdu_valid && rdy;
        byp  = BYP && acc && mdu_rd != 0 && n == 0 && !wbw;
        e_we = 0; e_a3 = 0; e_wd = 0; ret = 0;
        if (!rst) begin
            if (wbw) begin
                e_we = 1; e_a3 = wb_rd; e_wd = wb_wd;
            end else if (pop) begin
                e_we = 1; e_a3 = mq[0].rd; e_wd = mq[0].wd; ret = mq[0].rd;
            end else if (byp) begin
                e_we = 1; e_a3 = mdu_rd; e_wd = mdu_wd; ret = mdu_rd;
            end
        end
        st = 0;
        regs[0] = dec_rs1; regs[1] = dec_rs2; regs[2] = dec_rd;
        if (!rst && dec_valid) begin
            foreach (regs[k]) begin
                if (regs[k] != 0 && mbusy[regs[k]] && regs[k] != ret) st = 1;
            end
        end
        chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
        chk("rf_a3", {27'd0, rf_a3}, {27'd0, e_a3});
        chk("rf_wd", rf_wd, e_wd);
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, rdy});
        chk("stall", {31'd0, stall}, {31'd0, st});
        chk("buf_cnt", 32'(buf_cnt), 32'(n));
        if (rst) begin
            mq.delete();
            foreach (mbusy[k]) mbusy[k] = 0;
            m_acc = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc && mdu_rd != 0 && !byp) mq.push_back('{rd: mdu_rd, wd: mdu_wd});
            if (ret != 0) mbusy[ret] = 0;
            if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1;
            m_acc = acc;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rst = n_rst; wb_we = n_wb_we; wb_rd = n_wb_rd; wb_wd = n_wb_wd;
        mdu_valid = n_mdu_valid; mdu_rd = n_mdu_rd; mdu_wd = n_mdu_wd;
        iss_valid = n_iss_valid; iss_rd = n_iss_rd;
        dec_valid = n_dec_valid; dec_rs1 = n_rs1; dec_rs2 = n_rs2; dec_rd = n_drd;
        #1;
        model_check();
    endtask

    logic [4:0] pend[$];

    initial begin
        bit         offered, issued;
        logic [4:0] pick;
        clr();
        rst = 1; wb_we = 0; wb_rd = 0; wb_wd = 0; mdu_valid = 0; mdu_rd = 0; mdu_wd = 0;
        iss_valid = 0; iss_rd = 0; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        foreach (mbusy[k]) mbusy[k] = 0;
        m_acc = 0;
        repeat (2) @(posedge clk);

        // outputs held quiet while reset is asserted
        clr(); n_rst = 1; n_wb_we = 1; n_wb_rd = 5; n_mdu_valid = 1; n_mdu_rd = 3;
        n_dec_valid = 1; n_rs1 = 4; cyc();
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_ready", {31'd0, mdu_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        clr(); cyc();
        chk("post_rst_cnt", 32'(buf_cnt), 32'd0);

        // WB wins the port; MDU result lands the following idle cycle
        clr(); n_wb_we = 1; n_wb_rd = 5; n_wb_wd = 32'h11;
        n_mdu_valid = 1; n_mdu_rd = 6; n_mdu_wd = 32'h66; cyc();
        chk("wbpri_a3", {27'd0, rf_a3}, 32'd5);
        chk("wbpri_wd", rf_wd, 32'h11);
        clr(); cyc();
        chk("wbpri_cnt1", 32'(buf_cnt), 32'd1);
        chk("wbpri_x6", {27'd0, rf_a3}, 32'd6);
        clr(); cyc();
        chk("wbpri_cnt0", 32'(buf_cnt), 32'd0);

        // backpressure: third offer waits for the first WB-idle cycle
        for (int i = 0; i < 4; i++) begin
            clr(); n_wb_we = 1; n_wb_rd = 5'(10 + i); n_wb_wd = 32'(i);
            n_mdu_valid = 1; n_mdu_rd = 5'((i < 2) ? i + 1 : 3); n_mdu_wd = 32'(8'hA0 + ((i < 2) ? i : 2));
            cyc();
            if (i >= 2) chk("full_ready", {31'd0, mdu_ready}, 32'd0);
        end
        clr(); n_mdu_valid = 1; n_mdu_rd = 3; n_mdu_wd = 32'hA2; cyc();
        chk("drain_ready", {31'd0, mdu_ready}, 32'd1);
        chk("drain_a3_1", {27'd0, rf_a3}, 32'd1);
        clr(); cyc();
        chk("drain_a3_2", {27'd0, rf_a3}, 32'd2);
        clr(); cyc();
        chk("drain_a3_3", {27'd0, rf_a3}, 32'd3);
        chk("drain_wd_3", rf_wd, 32'hA2);
        clr(); cyc();

        // RAW stall on a pending MDU destination, released in the retire cycle
        clr(); n_iss_valid = 1; n_iss_rd = 7; cyc();
        clr(); n_dec_valid = 1; n_rs1 = 7; cyc();
        chk("raw_stall", {31'd0, stall}, 32'd1);
        clr(); n_dec_valid = 1; n_rs1 = 7; n_mdu_valid = 1; n_mdu_rd = 7; n_mdu_wd = 32'h77; cyc();
`ifdef RF_WB_ARB_BYPASS_EN
        chk("raw_ret_stall", {31'd0, stall}, 32'd0);
        chk("raw_ret_a3", {27'd0, rf_a3}, 32'd7);
`else
        chk("raw_acc_stall", {31'd0, stall}, 32'd1);
        clr(); n_dec_valid = 1; n_rs1 = 7; cyc();
        chk("raw_ret_stall", {31'd0, stall}, 32'd0);
        chk("raw_ret_a3", {27'd0, rf_a3}, 32'd7);
`endif
        clr(); n_dec_valid = 1; n_rs1 = 7; cyc();
        chk("raw_clear", {31'd0, stall}, 32'd0);

        // reissue in the retire cycle keeps the register busy
        clr(); n_iss_valid = 1; n_iss_rd = 9; cyc();
        clr(); n_mdu_valid = 1; n_mdu_rd = 9; n_mdu_wd = 32'h99;
`ifdef RF_WB_ARB_BYPASS_EN
        n_iss_valid = 1; n_iss_rd = 9; cyc();
`else
        cyc();
        clr(); n_iss_valid = 1; n_iss_rd = 9; cyc();
`endif
        chk("reiss_a3", {27'd0, rf_a3}, 32'd9);
        clr(); n_dec_valid = 1; n_rs2 = 9; cyc();
        chk("reiss_stall", {31'd0, stall}, 32'd1);
        clr(); n_mdu_valid = 1; n_mdu_rd = 9; cyc();
        clr(); cyc();

        // empty buffer, idle WB: zero-latency with bypass, one cycle without
        clr(); n_mdu_valid = 1; n_mdu_rd = 3; n_mdu_wd = 32'hAB; cyc();
`ifdef RF_WB_ARB_BYPASS_EN
        chk("byp_we", {31'd0, rf_we}, 32'd1);
        chk("byp_wd", rf_wd, 32'hAB);
        clr(); cyc();
        chk("byp_cnt", 32'(buf_cnt), 32'd0);
`else
        chk("nobyp_we0", {31'd0, rf_we}, 32'd0);
        clr(); cyc();
        chk("nobyp_we1", {31'd0, rf_we}, 32'd1);
        chk("nobyp_wd", rf_wd, 32'hAB);
`endif

        // reset mid-operation discards buffer and scoreboard
        clr(); n_iss_valid = 1; n_iss_rd = 4; n_wb_we = 1; n_wb_rd = 12;
        n_mdu_valid = 1; n_mdu_rd = 20; cyc();
        clr(); n_wb_we = 1; n_wb_rd = 13; n_mdu_valid = 1; n_mdu_rd = 21; cyc();
        clr(); n_wb_we = 1; n_wb_rd = 14; n_dec_valid = 1; n_rs1 = 4; cyc();
        chk("prerst_cnt", 32'(buf_cnt), 32'd2);
        chk("prerst_stall", {31'd0, stall}, 32'd1);
        clr(); n_rst = 1; n_wb_we = 1; n_wb_rd = 15; n_dec_valid = 1; n_rs1 = 4; cyc();
        chk("midrst_we", {31'd0, rf_we}, 32'd0);
        clr(); n_dec_valid = 1; n_rs1 = 4; cyc();
        chk("postrst_cnt", 32'(buf_cnt), 32'd0);
        chk("postrst_stall", {31'd0, stall}, 32'd0);
        chk("postrst_we", {31'd0, rf_we}, 32'd0);

        // randomized traffic obeying issue-order retirement
        pend.delete();
        for (int c = 0; c < 3000; c++) begin
            clr();
            offered = 0; issued = 0;
            n_rst   = ($urandom_range(0, 199) == 0);
            n_wb_we = ($urandom_range(0, 9) < 6);
            n_wb_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            n_wb_wd = $urandom;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                n_mdu_valid = 1; n_mdu_rd = pend[0]; n_mdu_wd = $urandom; offered = 1;
            end else if ($urandom_range(0, 9) == 0) begin
                n_mdu_valid = 1; n_mdu_rd = 0; n_mdu_wd = $urandom;
            end
            pick = 5'($urandom_range(1, 31));
            if (pend.size() < 4 && $urandom_range(0, 2) == 0 && !mbusy[pick]) begin
                n_iss_valid = 1; n_iss_rd = pick; issued = 1;
            end
            n_dec_valid = $urandom_range(0, 1);
            n_rs1 = (pend.size() > 0 && $urandom_range(0, 1) == 1) ? pend[$] : 5'($urandom_range(0, 31));
            n_rs2 = 5'($urandom_range(0, 31));
            n_drd = 5'($urandom_range(0, 31));
            cyc();
            if (n_rst) begin
                pend.delete();
            end else begin
                if (offered && m_acc) void'(pend.pop_front());
                if (issued) pend.push_back(pick);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, MDU result buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports wb_we/wb_rd/wb_wd  input  1/5/32  pipeline WB-stage write request.
REQ-005 SHALL have ports mdu_valid/mdu_rd/mdu_wd  input  1/5/32  multi-cycle unit result offer.
REQ-006 SHALL have port mdu_ready  output  1  result accepted this cycle when mdu_valid & mdu_ready.
REQ-007 SHALL have ports iss_valid/iss_rd  input  1/5  multi-cycle op issued, destination rd.
REQ-008 SHALL have ports dec_valid/dec_rs1/dec_rs2/dec_rd  input  1/5/5/5  decode-stage operand query.
REQ-009 SHALL have port stall  output  1  decode must hold.
REQ-010 SHALL have ports rf_we/rf_a3/rf_wd  output  1/5/32  drive the register-file write port (RFWr/A3/WD).
REQ-011 SHALL have port buf_cnt  output  $clog2(DEPTH)+1  buffered MDU results.

Function
REQ-012 SHALL grant the RF write port to WB whenever wb_we=1 and wb_rd!=0; WB is never delayed.
REQ-013 SHALL otherwise write the oldest buffered MDU result (FIFO order) and pop it in the same cycle.
REQ-014 SHALL drive rf_we=0, rf_a3=0, rf_wd=0 when neither source writes.
REQ-015 SHALL assert mdu_ready combinationally when buf_cnt<DEPTH, or when buf_cnt=DEPTH and a pop occurs this cycle.
REQ-016 SHALL accept an offer with mdu_rd=0 (mdu_ready rules unchanged) and discard it without buffering or writing.
REQ-017 SHALL drop WB writes with wb_rd=0 (rf_we=0); the MDU buffer head may drain that cycle.
REQ-018 SHALL keep buf_cnt unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-019 SHALL keep a scoreboard busy[31:1]: set on iss_valid with iss_rd!=0, clear when an MDU result to that register is written to RF.
REQ-020 SHALL give set priority over clear when both hit the same register in one cycle.
REQ-021 SHALL assert stall = dec_valid & (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]); register 0 never busy.
REQ-022 SHALL exclude from the stall term any register being retired by MDU this cycle (RF bypass supplies WD).
REQ-023 SHALL retire MDU results in issue order; iss_valid to an already-busy register never occurs (decode stalls WAW).

Reset
REQ-024 SHALL on rst=1 at posedge clk clear buffer, pointers, busy[], buf_cnt=0.
REQ-025 SHALL hold during and after reset: rf_we=0, stall=0, mdu_ready=1.
REQ-026 SHALL discard buffered results and in-flight scoreboard state on reset mid-operation; no RF write follows.

Configuration
REQ-027 SHALL, with RF_WB_ARB_BYPASS_EN defined, write an accepted MDU result directly to RF in the acceptance cycle when buffer empty and WB not writing (zero latency, no push).
REQ-028 SHALL, without RF_WB_ARB_BYPASS_EN, always push accepted results; earliest RF write is the next cycle.

Verification
REQ-029 SHALL cover: wb_we=1,wb_rd=5,wb_wd=0x11 with mdu_valid=1,mdu_rd=6 -> rf_a3=5,rf_wd=0x11; x6 written next idle cycle, buf_cnt 1->0.
REQ-030 SHALL cover: wb_we=1 for 4 cycles, 3 MDU offers, DEPTH=2 -> third offer sees mdu_ready=0 until first WB-idle cycle; results retire in offer order.
REQ-031 SHALL cover: iss_valid rd=7, then dec_rs1=7 -> stall=1 until cycle x7 is MDU-written; stall=0 in that cycle.
REQ-032 SHALL cover: MDU result rd=9 retires same cycle iss_valid rd=9 -> busy[9] stays 1.
REQ-033 SHALL cover: buffer empty, WB idle, mdu_valid rd=3 wd=0xAB -> rf_we=1 same cycle with RF_WB_ARB_BYPASS_EN, next cycle without.
REQ-034 SHALL cover: rst=1 with buf_cnt=2, busy[4]=1 -> next cycle buf_cnt=0, stall=0 for rs1=4, no RF write.
